// File: rtl/hifi4_dram_bank_model.sv
// hifi4_dram_bank_model: NUM_BANKS independent DataRAM banks, 1/2-cycle read,
// with deterministic per-bank Busy injection every BUSY_PERIOD-th request.
// Ports: CLK, BResetN (async low); per bank DRamAddr/En/Wr/ByteEn/WrData in,
// DRamBusy (registered reject flag) and DRamData (registered read data) out.
module hifi4_dram_bank_model #(
  parameter int NUM_BANKS   = 2,
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 64,
  parameter int LATENCY     = 1,
  parameter int BUSY_PERIOD = 0,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                            CLK,
  input  logic                            BResetN,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] DRamAddr,
  input  logic [NUM_BANKS-1:0]            DRamEn,
  input  logic [NUM_BANKS-1:0]            DRamWr,
  input  logic [NUM_BANKS*BE_WIDTH-1:0]   DRamByteEn,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] DRamWrData,
  output logic [NUM_BANKS-1:0]            DRamBusy,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] DRamData
);

  if (BUSY_PERIOD == 1 || BUSY_PERIOD < 0) begin : g_bad_busy
    $error("BUSY_PERIOD must be 0 or >= 2");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_bad_banks
    $error("NUM_BANKS must be 1..4");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
    $error("LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128)
  begin : g_bad_dw
    $error("DATA_WIDTH must be 32, 64 or 128");
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  rej;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ret_vld;
    logic [DATA_WIDTH-1:0] ret_word;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign addr   = DRamAddr[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata  = DRamWrData[b*DATA_WIDTH +: DATA_WIDTH];
    assign be     = DRamByteEn[b*BE_WIDTH +: BE_WIDTH];
    assign acc_wr = DRamEn[b] & ~rej & DRamWr[b];
    assign acc_rd = DRamEn[b] & ~rej & ~DRamWr[b];

    // Counter advances on requests only; a reject restarts it so the
    // core's retry is always accepted.
    if (BUSY_PERIOD >= 2) begin : g_busy
      localparam int CW = (BUSY_PERIOD > 2) ? $clog2(BUSY_PERIOD) : 1;
      logic [CW-1:0] cnt;

      assign rej = DRamEn[b] && (cnt == CW'(BUSY_PERIOD - 1));

      always_ff @(posedge CLK or negedge BResetN) begin
        if (!BResetN) begin
          cnt <= '0;
        end else if (DRamEn[b]) begin
          cnt <= rej ? '0 : cnt + CW'(1);
        end
      end
    end else begin : g_nobusy
      assign rej = 1'b0;
    end

    always_ff @(posedge CLK or negedge BResetN) begin
      if (!BResetN) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= rej;
      end
    end

    // Array is not reset; contents survive BResetN.
    always_ff @(posedge CLK) begin
      if (acc_wr) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end
    end

    assign rd_word = mem[addr];

    if (LATENCY == 2) begin : g_lat2
      logic                  s_vld;
      logic [DATA_WIDTH-1:0] s_data;

      always_ff @(posedge CLK or negedge BResetN) begin
        if (!BResetN) begin
          s_vld  <= 1'b0;
          s_data <= '0;
        end else begin
          s_vld <= acc_rd;
          if (acc_rd) begin
            s_data <= rd_word;
          end
        end
      end

      assign ret_vld  = s_vld;
      assign ret_word = s_data;
    end else begin : g_lat1
      assign ret_vld  = acc_rd;
      assign ret_word = rd_word;
    end

    // Output register only moves on a completing read.
    always_ff @(posedge CLK or negedge BResetN) begin
      if (!BResetN) begin
        data_q <= '0;
      end else if (ret_vld) begin
        data_q <= ret_word;
      end
    end

    assign DRamBusy[b] = busy_q;
    assign DRamData[b*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

endmodule
